// File: rtl/chicken_turn_ctrl_if.sv
// Keypad/reveal handshake bundle between the turn controller and the display datapath.
interface chicken_turn_ctrl_if #(
  parameter int KEY_W = 4
);
  logic             key_valid;
  logic [KEY_W-1:0] key;
  logic             reveal_done;
  logic             match;
  logic [KEY_W-1:0] sel_tile;
  logic             reveal_req;

  modport master (
    input  key_valid, key, reveal_done, match,
    output sel_tile, reveal_req
  );

  modport slave (
    output key_valid, key, reveal_done, match,
    input  sel_tile, reveal_req
  );
endinterface

// File: rtl/chicken_turn_ctrl.sv
// Chicken board-game turn controller: select, reveal handshake, move/rotate, win detection.
// Optional SELECT-state turn forfeit timer enabled by defining TURN_TIMEOUT_EN.
module chicken_turn_ctrl #(
  parameter int NUM_PLAYERS = 4,
  parameter int BOARD_LEN   = 24,
  parameter int KEY_W       = 4,
  parameter int TIMEOUT_CYC = 1000,
  localparam int PW    = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
  localparam int POS_W = $clog2(BOARD_LEN + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  chicken_turn_ctrl_if.master          bus,
  output logic [PW-1:0]                cur_player,
  output logic [NUM_PLAYERS*POS_W-1:0] pos,
  output logic                         win,
  output logic [PW-1:0]                winner,
  output logic                         timeout,
  output logic [2:0]                   state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_REVEAL = 3'd2,
    S_MOVE   = 3'd3,
    S_NEXT   = 3'd4,
    S_WIN    = 3'd5
  } state_t;

  state_t                         state_q, state_d;
  logic [KEY_W-1:0]               sel_q, sel_d;
  logic                           req_q, req_d;
  logic [PW-1:0]                  cur_q, cur_d;
  logic [NUM_PLAYERS*POS_W-1:0]   pos_q, pos_d;
  logic                           win_q, win_d;
  logic [PW-1:0]                  winner_q, winner_d;
  logic [POS_W-1:0]               cur_pos;
  logic [POS_W:0]                 pos_inc;
  logic                           key_ok;

  assign key_ok  = bus.key_valid && (bus.key != {KEY_W{1'b1}});
  assign cur_pos = pos_q[cur_q*POS_W +: POS_W];
  // One extra bit so the win compare cannot wrap at BOARD_LEN = 2**POS_W - 1.
  assign pos_inc = {1'b0, cur_pos} + 1'b1;

`ifdef TURN_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;

  // Counts cycles spent in SELECT; anything else (including each new entry) restarts it.
  always_comb begin
    cnt_d = '0;
    if (state_q == S_SELECT) cnt_d = cnt_q + 1'b1;
  end
`endif

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    req_d    = req_q;
    cur_d    = cur_q;
    pos_d    = pos_q;
    win_d    = win_q;
    winner_d = winner_q;
`ifdef TURN_TIMEOUT_EN
    to_d     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SELECT;
          pos_d   = '0;
          cur_d   = '0;
        end
      end
      S_SELECT: begin
        if (key_ok) begin
          sel_d   = bus.key;
          req_d   = 1'b1;
          state_d = S_REVEAL;
        end
`ifdef TURN_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          to_d    = 1'b1;
          state_d = S_NEXT;
        end
`endif
      end
      S_REVEAL: begin
        if (bus.reveal_done) begin
          req_d   = 1'b0;
          state_d = bus.match ? S_MOVE : S_NEXT;
        end
      end
      S_MOVE: begin
        if (pos_inc >= (POS_W+1)'(BOARD_LEN)) begin
          pos_d[cur_q*POS_W +: POS_W] = POS_W'(BOARD_LEN);
          winner_d = cur_q;
          win_d    = 1'b1;
          state_d  = S_WIN;
        end else begin
          pos_d[cur_q*POS_W +: POS_W] = pos_inc[POS_W-1:0];
          state_d  = S_SELECT;
        end
      end
      S_NEXT: begin
        cur_d   = (cur_q == PW'(NUM_PLAYERS - 1)) ? '0 : cur_q + 1'b1;
        state_d = S_SELECT;
      end
      S_WIN: begin
        if (start) begin
          win_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      req_q    <= 1'b0;
      cur_q    <= '0;
      pos_q    <= '0;
      win_q    <= 1'b0;
      winner_q <= '0;
`ifdef TURN_TIMEOUT_EN
      cnt_q    <= '0;
      to_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      req_q    <= req_d;
      cur_q    <= cur_d;
      pos_q    <= pos_d;
      win_q    <= win_d;
      winner_q <= winner_d;
`ifdef TURN_TIMEOUT_EN
      cnt_q    <= cnt_d;
      to_q     <= to_d;
`endif
    end
  end

`ifdef TURN_TIMEOUT_EN
  assign timeout = to_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
  assign timeout = 1'b0;
`endif

  assign state          = state_q;
  assign bus.sel_tile   = sel_q;
  assign bus.reveal_req = req_q;
  assign cur_player     = cur_q;
  assign pos            = pos_q;
  assign win            = win_q;
  assign winner         = winner_q;

endmodule
